// File: rtl/mem_arbiter.sv
// Single-owner arbiter that shares the memory controller request port between
// instruction fetch, data load and data store.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_len,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [2:0]        st_len,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              mc_valid,
    output logic              mc_is_write,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_len,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_LD, BUSY_ST, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                mc_valid_q, mc_valid_d;
    logic                mc_is_write_q, mc_is_write_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic [2:0]          mc_len_q, mc_len_d;
    logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
    logic                if_done_q, if_done_d;
    logic                ld_done_q, ld_done_d;
    logic                st_done_q, st_done_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   ld_data_q, ld_data_d;
    logic                starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        mc_valid_d    = mc_valid_q;
        mc_is_write_d = mc_is_write_q;
        mc_addr_d     = mc_addr_q;
        mc_len_d      = mc_len_q;
        mc_wdata_d    = mc_wdata_q;
        if_done_d     = 1'b0;
        ld_done_d     = 1'b0;
        st_done_d     = 1'b0;
        if_data_d     = if_data_q;
        ld_data_d     = ld_data_q;

        // rdy low freezes everything; done pulses fall because of the defaults above
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        starve_cnt_d = '0;
                    end else if (if_req && (starved || !(st_req || ld_req))) begin
                        state_d       = BUSY_IF;
                        starve_cnt_d  = '0;
                        mc_valid_d    = 1'b1;
                        mc_is_write_d = 1'b0;
                        mc_addr_d     = if_addr;
                        mc_len_d      = 3'd4;
                        mc_wdata_d    = '0;
                    end else if (st_req || ld_req) begin
                        state_d       = st_req ? BUSY_ST : BUSY_LD;
                        mc_valid_d    = 1'b1;
                        mc_is_write_d = st_req;
                        mc_addr_d     = st_req ? st_addr : ld_addr;
                        mc_len_d      = st_req ? st_len : ld_len;
                        mc_wdata_d    = st_req ? st_data : '0;
                        if (if_req && !starved) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
                BUSY_IF: begin
                    if (mc_done) begin
                        mc_valid_d = 1'b0;
                        state_d    = IDLE;
                        if (!clear) begin
                            if_done_d = 1'b1;
                            if_data_d = mc_rdata;
                        end
                    end else if (clear) begin
                        state_d = DRAIN;
                    end
                end
                BUSY_LD: begin
                    if (mc_done) begin
                        mc_valid_d = 1'b0;
                        state_d    = IDLE;
                        if (!clear) begin
                            ld_done_d = 1'b1;
                            ld_data_d = mc_rdata;
                        end
                    end else if (clear) begin
                        state_d = DRAIN;
                    end
                end
                // Stores are already committed, so a flush never cancels them
                BUSY_ST: begin
                    if (mc_done) begin
                        mc_valid_d = 1'b0;
                        st_done_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end
                DRAIN: begin
                    if (mc_done) begin
                        mc_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            mc_valid_q    <= 1'b0;
            mc_is_write_q <= 1'b0;
            mc_addr_q     <= '0;
            mc_len_q      <= '0;
            mc_wdata_q    <= '0;
            if_done_q     <= 1'b0;
            ld_done_q     <= 1'b0;
            st_done_q     <= 1'b0;
            if_data_q     <= '0;
            ld_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            mc_valid_q    <= mc_valid_d;
            mc_is_write_q <= mc_is_write_d;
            mc_addr_q     <= mc_addr_d;
            mc_len_q      <= mc_len_d;
            mc_wdata_q    <= mc_wdata_d;
            if_done_q     <= if_done_d;
            ld_done_q     <= ld_done_d;
            st_done_q     <= st_done_d;
            if_data_q     <= if_data_d;
            ld_data_q     <= ld_data_d;
        end
    end

    assign mc_valid    = mc_valid_q;
    assign mc_is_write = mc_is_write_q;
    assign mc_addr     = mc_addr_q;
    assign mc_len      = mc_len_q;
    assign mc_wdata    = mc_wdata_q;
    assign if_done     = if_done_q;
    assign ld_done     = ld_done_q;
    assign st_done     = st_done_q;
    assign if_data     = if_data_q;
    assign ld_data     = ld_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_req, ld_req, st_req;
    logic [31:0] if_addr, ld_addr, st_addr, st_data;
    logic [2:0]  ld_len, st_len;
    logic        if_done, ld_done, st_done;
    logic [31:0] if_data, ld_data;
    logic        mc_valid, mc_is_write, mc_done;
    logic [31:0] mc_addr, mc_wdata, mc_rdata;
    logic [2:0]  mc_len;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [2:0]  l;
        logic [31:0] d;
    } grant_t;

    typedef struct packed {
        logic [1:0]  k;   // 0 fetch, 1 load, 2 store
        logic [31:0] d;
    } done_t;

    grant_t exp_g[$];
    done_t  exp_d[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done),
        .mc_valid(mc_valid), .mc_is_write(mc_is_write), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: checks each new grant and each completion against the scoreboard
    logic prev_valid = 1'b0;
    logic prev_done  = 1'b0;
    always @(negedge clk) begin : monitor
        grant_t     g;
        done_t      e;
        logic [2:0] dn;
        logic [1:0] kind;
        logic [31:0] data;
        dn = {if_done, ld_done, st_done};
        if (mc_valid && !prev_valid) begin
            if (exp_g.size() == 0) begin
                fail_now("unexpected_grant");
            end else begin
                g = exp_g.pop_front();
                chk("grant_is_write", 32'(mc_is_write), 32'(g.w));
                chk("grant_addr", mc_addr, g.a);
                chk("grant_len", 32'(mc_len), 32'(g.l));
                chk("grant_wdata", mc_wdata, g.d);
            end
        end
        if (dn != 3'b000) begin
            chk("done_onehot", 32'($countones(dn)), 32'd1);
            chk("done_not_consecutive", 32'(prev_done), 32'd0);
            kind = if_done ? 2'd0 : (ld_done ? 2'd1 : 2'd2);
            data = if_done ? if_data : (ld_done ? ld_data : 32'd0);
            if (exp_d.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                e = exp_d.pop_front();
                chk("done_kind", 32'(kind), 32'(e.k));
                chk("done_data", data, e.d);
            end
        end
        prev_valid = mc_valid;
        prev_done  = |dn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !mc_valid; i++) tick();
        if (!mc_valid) fail_now("timeout_waiting_for_mc_valid");
    endtask

    // Controller model: answer the current request after lat cycles, requester drops on done
    task automatic complete(input int lat, input logic [31:0] rd);
        wait_valid();
        repeat (lat) tick();
        mc_done  = 1'b1;
        mc_rdata = rd;
        tick();
        mc_done = 1'b0;
        if (st_done) st_req = 1'b0;
        if (ld_done) ld_req = 1'b0;
        if (if_done) if_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mc_valid"}, 32'(mc_valid), 32'd0);
        chk({tag, "_mc_is_write"}, 32'(mc_is_write), 32'd0);
        chk({tag, "_mc_addr"}, mc_addr, 32'd0);
        chk({tag, "_mc_len"}, 32'(mc_len), 32'd0);
        chk({tag, "_mc_wdata"}, mc_wdata, 32'd0);
        chk({tag, "_dones"}, 32'({if_done, ld_done, st_done}), 32'd0);
        chk({tag, "_if_data"}, if_data, 32'd0);
        chk({tag, "_ld_data"}, ld_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0;
        ld_len = '0; st_len = '0; mc_done = 1'b0; mc_rdata = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Priority: store, then load, then fetch
        exp_g.push_back('{1'b1, 32'h200, 3'd4, 32'hDEADBEEF});
        exp_g.push_back('{1'b0, 32'h100, 3'd2, 32'h0});
        exp_g.push_back('{1'b0, 32'h40, 3'd4, 32'h0});
        exp_d.push_back('{2'd2, 32'h0});
        exp_d.push_back('{2'd1, 32'h0000BEEF});
        exp_d.push_back('{2'd0, 32'h13579BDF});
        if_addr = 32'h40; if_req = 1'b1;
        ld_addr = 32'h100; ld_len = 3'd2; ld_req = 1'b1;
        st_addr = 32'h200; st_len = 3'd4; st_data = 32'hDEADBEEF; st_req = 1'b1;
        complete(2, 32'hFFFF_FFFF);
        complete(1, 32'h0000BEEF);
        complete(3, 32'h13579BDF);
        tick();

        // Reset in the middle of a load abandons it
        exp_g.push_back('{1'b0, 32'h180, 3'd4, 32'h0});
        ld_addr = 32'h180; ld_len = 3'd4; ld_req = 1'b1;
        wait_valid();
        tick();
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        ld_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        mc_done = 1'b1; mc_rdata = 32'h77;
        tick();
        mc_done = 1'b0;
        tick();
        chk("post_reset_no_ld_done", 32'(ld_done), 32'd0);
        exp_g.push_back('{1'b0, 32'h80, 3'd4, 32'h0});
        exp_d.push_back('{2'd0, 32'hA5A5A5A5});
        if_addr = 32'h80; if_req = 1'b1;
        complete(1, 32'hA5A5A5A5);
        tick();

        // Starvation: four stores, the pending fetch, then the last two stores
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                exp_g.push_back('{1'b0, 32'h1000, 3'd4, 32'h0});
                exp_d.push_back('{2'd0, 32'h600D0000});
            end
            exp_g.push_back('{1'b1, 32'h2000 + 32'(4 * k), 3'd4, 32'h1000_0000 + 32'(k)});
            exp_d.push_back('{2'd2, 32'h0});
        end
        begin
            int k;
            k = 0;
            if_addr = 32'h1000; if_req = 1'b1;
            st_addr = 32'h2000; st_len = 3'd4; st_data = 32'h1000_0000; st_req = 1'b1;
            for (int n = 0; n < 7; n++) begin
                complete(1, (n == 4) ? 32'h600D0000 : 32'h0);
                if (!st_req && k < 5) begin
                    k++;
                    st_addr = 32'h2000 + 32'(4 * k);
                    st_data = 32'h1000_0000 + 32'(k);
                    st_req  = 1'b1;
                end
            end
        end
        tick();

        // Freeze: mc_done while rdy is low is ignored
        exp_g.push_back('{1'b0, 32'h500, 3'd4, 32'h0});
        exp_d.push_back('{2'd1, 32'h55AA55AA});
        ld_addr = 32'h500; ld_len = 3'd4; ld_req = 1'b1;
        wait_valid();
        rdy = 1'b0;
        mc_done = 1'b1; mc_rdata = 32'h11111111;
        tick();
        mc_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("freeze_mc_valid", 32'(mc_valid), 32'd1);
            chk("freeze_ld_done", 32'(ld_done), 32'd0);
            chk("freeze_mc_addr", mc_addr, 32'h500);
            tick();
        end
        rdy = 1'b1;
        tick();
        chk("resume_mc_valid", 32'(mc_valid), 32'd1);
        complete(1, 32'h55AA55AA);
        chk("freeze_ld_data", ld_data, 32'h55AA55AA);
        tick();

        // Flush during a load: completion discarded after drain
        exp_g.push_back('{1'b0, 32'h300, 3'd1, 32'h0});
        ld_addr = 32'h300; ld_len = 3'd1; ld_req = 1'b1;
        wait_valid();
        clear = 1'b1; ld_req = 1'b0;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_mc_valid_held", 32'(mc_valid), 32'd1);
            tick();
        end
        mc_done = 1'b1; mc_rdata = 32'h12;
        tick();
        mc_done = 1'b0;
        chk("drain_mc_valid_drop", 32'(mc_valid), 32'd0);
        chk("drain_ld_done", 32'(ld_done), 32'd0);
        chk("drain_ld_data_kept", ld_data, 32'h55AA55AA);
        tick();
        chk("drain_back_idle", 32'(mc_valid), 32'd0);

        // Flush during a store is ignored
        exp_g.push_back('{1'b1, 32'h400, 3'd4, 32'hCAFEF00D});
        exp_d.push_back('{2'd2, 32'h0});
        st_addr = 32'h400; st_len = 3'd4; st_data = 32'hCAFEF00D; st_req = 1'b1;
        wait_valid();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        complete(2, 32'h0);
        chk("flush_store_st_done", 32'(st_done), 32'd1);
        tick();
        chk("flush_store_st_done_drop", 32'(st_done), 32'd0);

        repeat (3) tick();
        chk("grants_outstanding", 32'(exp_g.size()), 32'd0);
        chk("dones_outstanding", 32'(exp_d.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
